// File: rtl/sram_like_bridge.sv
// sram_like_bridge: turns one mycpu_core SRAM-style port into a
// req/addr_ok/data_ok split-transaction bus request. At most one transaction
// is in flight; the core is stalled until the DONE cycle, when it samples
// cpu_rdata from a stable register.
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q;
  logic                bus_req_q;
  logic                bus_wr_q;
  logic [1:0]          bus_size_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic [STRB_W-1:0]   bus_wstrb_q;
  logic [DATA_W-1:0]   bus_wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q;

  logic                wr_d;
  logic [1:0]          size_d;

  // Access size from the strobe pattern: one lane -> byte, an aligned lane
  // pair -> half, everything else (full word, read, odd patterns) -> word.
  always_comb begin
    wr_d   = |cpu_wen;
    size_d = 2'd2;
    if ($countones(cpu_wen) == 1) begin
      size_d = 2'd0;
    end else begin
      for (int unsigned k = 0; k < STRB_W / 2; k++) begin
        if (cpu_wen == (STRB_W'(3) << (2 * k))) begin
          size_d = 2'd1;
        end
      end
    end
  end

  // Transaction FSM with registered bus fields and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_en) begin
            bus_addr_q  <= cpu_addr;
            bus_wstrb_q <= cpu_wen;
            bus_wdata_q <= cpu_wdata;
            bus_wr_q    <= wr_d;
            bus_size_q  <= size_d;
            bus_req_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // data_ok without addr_ok belongs to nothing we issued; ignore it.
          if (bus_addr_ok) begin
            bus_req_q <= 1'b0;
            if (bus_data_ok) begin
              if (!bus_wr_q) cpu_rdata_q <= bus_rdata;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (!bus_wr_q) cpu_rdata_q <= bus_rdata;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Core still presents the finished request here; never reissue it.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_stall = ((state_q == IDLE) && cpu_en) || (state_q == REQ) || (state_q == WAIT);
  assign cpu_rdata = cpu_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: inputs change 1ns after each rising
// edge, outputs are checked 1ns later, well clear of the next edge.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".req"},   bus_req,   1'b0);
    chk({tag, ".wr"},    bus_wr,    1'b0);
    chk({tag, ".size"},  bus_size,  2'd0);
    chk({tag, ".addr"},  bus_addr,  32'h0);
    chk({tag, ".wstrb"}, bus_wstrb, 4'h0);
    chk({tag, ".wdata"}, bus_wdata, 32'h0);
    chk({tag, ".rdata"}, cpu_rdata, 32'h0);
    chk({tag, ".stall"}, cpu_stall, 1'b0);
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk_idle_reset("reset");

    // 1: read, addr_ok with req, data_ok next cycle
    cyc();
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'hBFC0_0000; #1;
    chk("t1.idle_stall", cpu_stall, 1'b1);
    chk("t1.idle_req", bus_req, 1'b0);
    cyc();
    bus_addr_ok = 1'b1; #1;
    chk("t1.req", bus_req, 1'b1);
    chk("t1.addr", bus_addr, 32'hBFC0_0000);
    chk("t1.wr", bus_wr, 1'b0);
    chk("t1.size", bus_size, 2'd2);
    chk("t1.req_stall", cpu_stall, 1'b1);
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C08_BFAF; #1;
    chk("t1.wait_req", bus_req, 1'b0);
    chk("t1.wait_stall", cpu_stall, 1'b1);
    chk("t1.wait_rdata", cpu_rdata, 32'h0);
    cyc();
    bus_data_ok = 1'b0; #1;
    chk("t1.done_stall", cpu_stall, 1'b0);
    chk("t1.done_rdata", cpu_rdata, 32'h3C08_BFAF);
    cpu_en = 1'b0;
    cyc(); #1;
    chk("t1.idle_stall0", cpu_stall, 1'b0);
    chk("t1.idle_req0", bus_req, 1'b0);

    // 2: store byte, accepted and completed in the same REQ cycle
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h8000_0013; cpu_wdata = 32'h00AB_0000;
    cyc();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("t2.wr", bus_wr, 1'b1);
    chk("t2.size", bus_size, 2'd0);
    chk("t2.wstrb", bus_wstrb, 4'b0100);
    chk("t2.addr", bus_addr, 32'h8000_0013);
    chk("t2.wdata", bus_wdata, 32'h00AB_0000);
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("t2.done_stall", cpu_stall, 1'b0);
    chk("t2.rdata_kept", cpu_rdata, 32'h3C08_BFAF);
    cyc();

    // 3: halfword store, addr_ok withheld 5 cycles, stray data_ok in REQ
    cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h8000_0100; cpu_wdata = 32'h5566_0000;
    cyc();
    for (int i = 0; i < 5; i++) begin
      bus_addr_ok = 1'b0; bus_data_ok = (i == 2); bus_rdata = 32'hCAFE_0000 + 32'(i); #1;
      chk("t3.req", bus_req, 1'b1);
      chk("t3.addr", bus_addr, 32'h8000_0100);
      chk("t3.size", bus_size, 2'd1);
      chk("t3.wstrb", bus_wstrb, 4'b1100);
      chk("t3.stall", cpu_stall, 1'b1);
      cyc();
    end
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1; #1;
    chk("t3.still_req", bus_req, 1'b1);
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; #1;
    chk("t3.wait_req", bus_req, 1'b0);
    chk("t3.wait_stall", cpu_stall, 1'b1);
    cyc();
    bus_data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("t3.done_stall", cpu_stall, 1'b0);
    chk("t3.rdata_kept", cpu_rdata, 32'h3C08_BFAF);
    cyc();

    // 4: read with addr_ok and data_ok together, WAIT skipped
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h8000_0200;
    cyc();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("t4.done_stall", cpu_stall, 1'b0);
    chk("t4.rdata", cpu_rdata, 32'h1234_5678);
    chk("t4.req", bus_req, 1'b0);
    cyc();

    // 5: odd strobe pattern, then reset while in WAIT and a late data_ok
    cpu_en = 1'b1; cpu_wen = 4'b0101; cpu_addr = 32'h8000_0300; cpu_wdata = 32'h0011_0022;
    cyc();
    bus_addr_ok = 1'b1; #1;
    chk("t5.size", bus_size, 2'd2);
    chk("t5.wstrb", bus_wstrb, 4'b0101);
    cyc();
    bus_addr_ok = 1'b0; rst = 1'b1; cpu_en = 1'b0; #1;
    chk("t5.wait_stall", cpu_stall, 1'b1);
    cyc();
    rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_0000; #1;
    chk_idle_reset("t5.rst");
    cyc();
    bus_data_ok = 1'b0; #1;
    chk_idle_reset("t5.late");

    // 6: back-to-back reads with cpu_en held high through DONE
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h0000_1000;
    cyc();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_addr = 32'h0000_2004; #1;
    chk("t6.done_stall", cpu_stall, 1'b0);
    chk("t6.rdata1", cpu_rdata, 32'h1111_1111);
    cyc(); #1;
    chk("t6.idle_stall", cpu_stall, 1'b1);
    chk("t6.idle_req", bus_req, 1'b0);
    cyc();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h2222_2222; #1;
    chk("t6.req2", bus_req, 1'b1);
    chk("t6.addr2", bus_addr, 32'h0000_2004);
    cyc();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_en = 1'b0; #1;
    chk("t6.rdata2", cpu_rdata, 32'h2222_2222);
    chk("t6.done2_stall", cpu_stall, 1'b0);
    cyc(); #1;
    chk("t6.final_req", bus_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
